m_axis_out_buffer: RTL and testbench

Output buffer between the accelerator result path (the psum/pool output packers, which produce valid-only 32-bit words with no backpressure) and the external AXI-Stream master port. It absorbs result words into a circular FIFO and presents them on a standard M_AXIS interface that honours TREADY. It raises an almost-full stall flag so the controller can pause compute. Any word arriving while the buffer is full is dropped and flagged.

---
 rtl/m_axis_out_buffer_if.sv | 13 +
 rtl/m_axis_out_buffer.sv | 96 +++++++++
 tb/tb_m_axis_out_buffer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/m_axis_out_buffer_if.sv
// AXI-Stream bundle carried between the output buffer and its downstream sink.
interface m_axis_out_buffer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    tvalid;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;
  logic                    tready;

  modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/m_axis_out_buffer.sv
// Circular FIFO that absorbs unthrottled result words and replays them on an
// M_AXIS port honouring TREADY, with almost-full stall and sticky overflow.
module m_axis_out_buffer #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 16,
  parameter int ALMOST_FULL_MARGIN   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] in_data,
  input  logic                            in_last,
  input  logic                            clear,
  output logic                            stall,
  output logic                            overflow,
  output logic                            packet_done,
  output logic [15:0]                     tx_count,
  m_axis_out_buffer_if.master             m_axis
);

  localparam int DW    = C_M_AXIS_TDATA_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   STALL_TH  = (PTR_W+1)'(FIFO_DEPTH - ALMOST_FULL_MARGIN);

  logic [DW:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [DW:0]      head;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  assign head = mem[rd_ptr];
  assign full = (count == CNT_FULL);
  assign pop  = (count != '0) && m_axis.tready;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  assign m_axis.tvalid = (count != '0);
  assign m_axis.tdata  = head[DW-1:0];
  assign m_axis.tlast  = head[DW];
  assign m_axis.tstrb  = '1;
  assign stall         = (count >= STALL_TH);

  // Storage carries no reset; stale entries are never visible while count is 0.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= {in_last, in_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      packet_done <= 1'b0;
      tx_count    <= '0;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      packet_done <= 1'b0;
      tx_count    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      packet_done <= pop && head[DW];
      if (pop && (tx_count != 16'hFFFF)) begin
        tx_count <= tx_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_m_axis_out_buffer.sv
// Scoreboard bench: stimulus queues expected {last,data} words, a negedge
// monitor pops and compares every accepted AXI-Stream transfer.
module tb_m_axis_out_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        clear;
  logic        stall;
  logic        overflow;
  logic        packet_done;
  logic [15:0] tx_count;

  int checks = 0;
  int errors = 0;

  logic [32:0] sb [$];
  logic        held;
  logic [32:0] held_word;

  m_axis_out_buffer_if #(.DATA_WIDTH(32)) m_if ();

  m_axis_out_buffer #(
    .C_M_AXIS_TDATA_WIDTH(32),
    .FIFO_DEPTH(16),
    .ALMOST_FULL_MARGIN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .clear(clear),
    .stall(stall),
    .overflow(overflow),
    .packet_done(packet_done),
    .tx_count(tx_count),
    .m_axis(m_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: checks every transfer against the scoreboard and head stability under backpressure.
  always @(negedge clk) begin
    logic [32:0] got;
    logic [32:0] exp_word;
    if (rst) begin
      held = 1'b0;
    end else begin
      got = {m_if.tlast, m_if.tdata};
      if (held && m_if.tvalid) begin
        checks++;
        if (got !== held_word) begin
          errors++;
          $display("[TB] FAIL stability: got %h expected %h", got, held_word);
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_word: got %h expected none", got);
        end else begin
          exp_word = sb.pop_front();
          if (got !== exp_word) begin
            errors++;
            $display("[TB] FAIL stream_word: got %h expected %h", got, exp_word);
          end
        end
      end
      held      = m_if.tvalid && !m_if.tready;
      held_word = got;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic last, input bit accept);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    if (accept) sb.push_back({last, data});
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !m_if.tvalid) break;
      tick();
    end
    checkOutput({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    checkOutput({name, "_tvalid_low"}, {31'd0, m_if.tvalid}, 32'd0);
  endtask

  initial begin
    int sent;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    clear       = 1'b0;
    m_if.tready = 1'b0;

    tick();
    tick();
    checkOutput("rst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("rst_packet_done", {31'd0, packet_done}, 32'd0);
    checkOutput("rst_tx_count", {16'd0, tx_count}, 32'd0);
    checkOutput("rst_tstrb", {28'd0, m_if.tstrb}, 32'h0000000F);
    rst = 1'b0;
    tick();

    // Single word with one-cycle latency and packet_done pulse.
    m_if.tready = 1'b1;
    applyStimulus(32'hA5A5_0001, 1'b1, 1'b1);
    checkOutput("single_tvalid", {31'd0, m_if.tvalid}, 32'd1);
    checkOutput("single_tdata", m_if.tdata, 32'hA5A5_0001);
    checkOutput("single_tlast", {31'd0, m_if.tlast}, 32'd1);
    tick();
    checkOutput("single_packet_done", {31'd0, packet_done}, 32'd1);
    checkOutput("single_tx_count", {16'd0, tx_count}, 32'd1);
    tick();
    checkOutput("single_packet_done_fall", {31'd0, packet_done}, 32'd0);

    // Backpressure: 12 words, stall at count 12, then full-rate drain.
    m_if.tready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(32'(i), (i == 11), 1'b1);
      if (i == 10) checkOutput("bp_stall_11", {31'd0, stall}, 32'd0);
      if (i == 11) checkOutput("bp_stall_12", {31'd0, stall}, 32'd1);
    end
    m_if.tready = 1'b1;
    repeat (12) tick();
    checkOutput("bp_throughput_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    checkOutput("bp_throughput_sb", 32'(sb.size()), 32'd0);
    checkOutput("bp_tx_count", {16'd0, tx_count}, 32'd13);

    // Overflow: 17th word dropped, only 0..15 drain.
    m_if.tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(32'h200 + 32'(i), (i == 15), (i < 16));
      if (i == 15) checkOutput("ovf_before", {31'd0, overflow}, 32'd0);
      if (i == 16) checkOutput("ovf_set", {31'd0, overflow}, 32'd1);
    end
    checkOutput("ovf_stall", {31'd0, stall}, 32'd1);
    m_if.tready = 1'b1;
    repeat (16) tick();
    checkOutput("ovf_drained_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    checkOutput("ovf_tx_count", {16'd0, tx_count}, 32'd29);
    checkOutput("ovf_sticky", {31'd0, overflow}, 32'd1);
    checkOutput("ovf_packet_done", {31'd0, packet_done}, 32'd1);

    // Clear with 5 queued words and a concurrent push.
    m_if.tready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(32'h50 + 32'(i), 1'b0, 1'b1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    checkOutput("clr_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    checkOutput("clr_tx_count", {16'd0, tx_count}, 32'd0);
    checkOutput("clr_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("clr_stall", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("clr_push_lost", {31'd0, m_if.tvalid}, 32'd0);

    // Full FIFO with simultaneous push and pop keeps count at 16.
    for (int i = 0; i < 16; i++) applyStimulus(32'h300 + 32'(i), 1'b0, 1'b1);
    checkOutput("full_overflow", {31'd0, overflow}, 32'd0);
    m_if.tready = 1'b1;
    applyStimulus(32'h100, 1'b1, 1'b1);
    m_if.tready = 1'b0;
    checkOutput("full_pushpop_overflow", {31'd0, overflow}, 32'd0);
    applyStimulus(32'h999, 1'b0, 1'b0);
    checkOutput("full_still_16", {31'd0, overflow}, 32'd1);
    m_if.tready = 1'b1;
    waitDrain("full");
    checkOutput("full_tx_count", {16'd0, tx_count}, 32'd17);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("full_clear_overflow", {31'd0, overflow}, 32'd0);

    // Wrap-around: 40 words, TREADY toggling, producer honours stall.
    sent = 0;
    for (int c = 0; c < 400 && sent < 40; c++) begin
      m_if.tready = c[0];
      if (!stall) begin
        in_valid = 1'b1;
        in_data  = 32'h1000 + 32'(sent);
        in_last  = (sent == 39);
        sb.push_back({in_last, in_data});
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("wrap_sent", 32'(sent), 32'd40);
    m_if.tready = 1'b1;
    waitDrain("wrap");
    checkOutput("wrap_tx_count", {16'd0, tx_count}, 32'd40);
    checkOutput("wrap_overflow", {31'd0, overflow}, 32'd0);

    // Asynchronous reset mid-transfer.
    m_if.tready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(32'h700 + 32'(i), (i == 2), 1'b1);
    m_if.tready = 1'b1;
    tick();
    checkOutput("mid_tx_count", {16'd0, tx_count}, 32'd41);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    checkOutput("arst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    checkOutput("arst_tx_count", {16'd0, tx_count}, 32'd0);
    checkOutput("arst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("arst_packet_done", {31'd0, packet_done}, 32'd0);
    checkOutput("arst_stall", {31'd0, stall}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    applyStimulus(32'hCAFE_F00D, 1'b1, 1'b1);
    waitDrain("post_rst");
    checkOutput("post_rst_tx_count", {16'd0, tx_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
